// File: rtl/control_unit_vec_if.sv
// Control unit bus: instruction handshake, ALU compare flag, memory beat
// handshake, and the decoded control outputs.
//   slave  : view used by control_unit_vec
//   master : view used by the instruction source / datapath
interface control_unit_vec_if #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned MEM_PORTS = 1,
  parameter int unsigned ALUW      = 2
);
  localparam int unsigned BEATS = LANES / MEM_PORTS;
  localparam int unsigned BEATW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic             instr_valid;
  logic             instr_ready;
  logic [5:0]       opcode;
  logic             flag;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             reg_write;
  logic             pc_src;
  logic             add1_sel;
  logic             illegal;
  logic [LANES-1:0] lane_we;
  logic [BEATW-1:0] beat;
  logic [ALUW-1:0]  alu_control;
  logic [1:0]       source;

  modport slave (
    input  instr_valid, opcode, flag, mem_ready,
    output instr_ready, mem_req, mem_write, reg_write, pc_src, add1_sel,
           illegal, lane_we, beat, alu_control, source
  );

  modport master (
    output instr_valid, opcode, flag, mem_ready,
    input  instr_ready, mem_req, mem_write, reg_write, pc_src, add1_sel,
           illegal, lane_we, beat, alu_control, source
  );
endinterface

// File: rtl/control_unit_vec.sv
// Vector control unit: accepts 6-bit opcodes, decodes them into a one-cycle
// EXEC step or a multi-beat MEM transfer, and drives per-lane write enables.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - control_unit_vec_if.slave (handshake, flag, memory, decode outputs)
// Decode outputs are combinational from the latched opcode, state and
// mem_ready, so a load beat's lane enables line up with the accepted beat.
module control_unit_vec #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned MEM_PORTS = 1,
  parameter int unsigned ALUW      = 2
) (
  input logic           clk,
  input logic           reset,
  control_unit_vec_if.slave bus
);
  localparam int unsigned BEATS = LANES / MEM_PORTS;
  localparam int unsigned BEATW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [LANES-1:0] PORT_MASK = LANES'({MEM_PORTS{1'b1}});

  localparam logic [1:0] CLS_DATA   = 2'b00;
  localparam logic [1:0] CLS_MEM    = 2'b01;
  localparam logic [1:0] CLS_BRANCH = 2'b10;
  localparam logic [1:0] CLS_ILL    = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, MEM} state_t;

  state_t           state, state_nxt;
  logic [5:0]       instr_q;
  logic             flag_reg;
  logic [BEATW-1:0] beat_q;

  logic             cond, sub;
  logic [1:0]       cls, op;
  logic             accept_c, last_beat_c, cmp_exec_c;

  logic             instr_ready_c, mem_req_c, mem_write_c, reg_write_c;
  logic             pc_src_c, add1_sel_c, illegal_c;
  logic [LANES-1:0] lane_we_c;
  logic [ALUW-1:0]  alu_control_c;
  logic [1:0]       source_c;

  assign cond = instr_q[5];
  assign cls  = instr_q[4:3];
  assign op   = instr_q[2:1];
  assign sub  = instr_q[0];

  assign accept_c    = bus.instr_valid && (state != MEM);
  assign last_beat_c = (beat_q == BEATW'(BEATS - 1));
  assign cmp_exec_c  = (state == EXEC) && (cls == CLS_DATA) && (op == 2'b10) && sub;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Latched opcode, compare flag and beat counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q  <= '0;
      flag_reg <= 1'b0;
      beat_q   <= '0;
    end else begin
      if (accept_c)   instr_q  <= bus.opcode;
      if (cmp_exec_c) flag_reg <= bus.flag;
      if ((state == MEM) && bus.mem_ready)
        beat_q <= last_beat_c ? '0 : beat_q + BEATW'(1);
    end
  end

  // Next state and decode
  always_comb begin
    state_nxt     = state;
    instr_ready_c = (state != MEM);
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    reg_write_c   = 1'b0;
    pc_src_c      = 1'b0;
    add1_sel_c    = 1'b0;
    illegal_c     = 1'b0;
    lane_we_c     = '0;
    alu_control_c = '0;
    source_c      = 2'b00;

    unique case (state)
      IDLE: ;
      EXEC: begin
        alu_control_c = ALUW'(op);
        source_c      = cls;
        unique case (cls)
          CLS_DATA: begin
            if (op != 2'b10) begin
              reg_write_c = 1'b1;
              lane_we_c   = '1;
            end
            add1_sel_c = (op == 2'b01);
          end
          CLS_BRANCH: pc_src_c  = !cond || flag_reg;
          CLS_ILL:    illegal_c = 1'b1;
          default: ;
        endcase
      end
      MEM: begin
        alu_control_c = ALUW'(op);
        source_c      = cls;
        mem_req_c     = 1'b1;
        mem_write_c   = !sub;
        if (sub && bus.mem_ready) begin
          reg_write_c = 1'b1;
          lane_we_c   = PORT_MASK << (MEM_PORTS * 32'(beat_q));
        end
        if (bus.mem_ready && last_beat_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // An accept overrides the default return to IDLE from EXEC
    if (accept_c)           state_nxt = (bus.opcode[4:3] == CLS_MEM) ? MEM : EXEC;
    else if (state == EXEC) state_nxt = IDLE;
  end

  assign bus.instr_ready = instr_ready_c;
  assign bus.mem_req     = mem_req_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.reg_write   = reg_write_c;
  assign bus.pc_src      = pc_src_c;
  assign bus.add1_sel    = add1_sel_c;
  assign bus.illegal     = illegal_c;
  assign bus.lane_we     = lane_we_c;
  assign bus.beat        = beat_q;
  assign bus.alu_control = alu_control_c;
  assign bus.source      = source_c;
endmodule
